// File: rtl/ramp_adc_scheduler.sv
// rtl/ramp_adc_scheduler.sv - round-robin ramp-ADC conversion scheduler
// Time-shares one comparator bit across NUM_CH muxed inputs and scales the averaged count.
module ramp_adc_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int AVG_POW        = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int SCALING_FACTOR = 79993,
  parameter int SHIFT_FACTOR   = 19
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic                      duty_data,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic                      sample_active,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_channel,
  output logic [15:0]               res_raw,
  output logic [15:0]               res_data
);

  localparam int CW      = $clog2(NUM_CH);
  localparam int ACQ_LEN = 2 ** (AVG_POW + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > ACQ_LEN) ? SETTLE_CYCLES : ACQ_LEN;
  localparam int CNTW    = $clog2(CNT_MAX);
  localparam int PW      = 16 + $clog2(SCALING_FACTOR) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] ACQUIRE = 3'd2;
  localparam logic [2:0] SCALE1  = 3'd3;
  localparam logic [2:0] SCALE2  = 3'd4;
  localparam logic [2:0] OUTPUT  = 3'd5;

  logic [2:0]         state;
  logic [CNTW-1:0]    cnt;
  logic [AVG_POW:0]   acc;
  logic [15:0]        ave_q;
  logic [PW-1:0]      prod;
  logic               picked;

  logic [CW-1:0]      start_ch;
  logic [NUM_CH-1:0]  rot;
  logic [CW-1:0]      offset;
  logic [CW:0]        sum;
  logic [CW-1:0]      next_ch;
  logic               found;
  logic [15:0]        ave_next;
  logic               strobe;

  assign sample_active = (state == ACQUIRE);
  assign busy          = (state != IDLE);
  // Strobe is the low bit of the acquire counter, so it starts at 0 and toggles every cycle.
  assign strobe        = cnt[0];

  // Until the first selection after reset the search begins at channel 0.
  always_comb begin
    start_ch = '0;
    if (picked && (mux_sel != CW'(NUM_CH - 1)))
      start_ch = mux_sel + CW'(1);
  end

  always_comb begin
    rot    = NUM_CH'({ch_enable, ch_enable} >> start_ch);
    found  = 1'b0;
    offset = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        offset = CW'(i);
      end
    end
    sum = {1'b0, start_ch} + {1'b0, offset};
    if (sum >= (CW+1)'(NUM_CH))
      sum = sum - (CW+1)'(NUM_CH);
    next_ch = sum[CW-1:0];
  end

  always_comb begin
    ave_next = 16'(acc[AVG_POW-1:0]) << (16 - AVG_POW);
    if (acc[AVG_POW])
      ave_next = 16'hFFFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      ave_q       <= '0;
      prod        <= '0;
      picked      <= 1'b0;
      mux_sel     <= '0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_raw     <= '0;
      res_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run && found) begin
            mux_sel <= next_ch;
            picked  <= 1'b1;
            cnt     <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNTW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            acc   <= '0;
            state <= ACQUIRE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        ACQUIRE: begin
          if (strobe)
            acc <= acc + (AVG_POW+1)'(duty_data);
          if (cnt == CNTW'(ACQ_LEN - 1))
            state <= SCALE1;
          else
            cnt <= cnt + CNTW'(1);
        end
        SCALE1: begin
          ave_q <= ave_next;
          prod  <= PW'(ave_next) * PW'(SCALING_FACTOR);
          state <= SCALE2;
        end
        SCALE2: begin
          res_data    <= 16'(prod >> SHIFT_FACTOR);
          res_raw     <= ave_q;
          res_channel <= mux_sel;
          res_valid   <= 1'b1;
          state       <= OUTPUT;
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (run && found) begin
              mux_sel <= next_ch;
              picked  <= 1'b1;
              cnt     <= '0;
              state   <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_adc_scheduler.sv
// tb/tb_ramp_adc_scheduler.sv - directed scoreboard bench for ramp_adc_scheduler
module tb_ramp_adc_scheduler;

  localparam int SF = 79993;
  localparam int SH = 19;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  ch_enable = 4'b0000;
  logic        duty_data = 1'b0;
  logic        res_ready = 1'b0;
  logic [1:0]  mux_sel;
  logic        sample_active;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_channel;
  logic [15:0] res_raw;
  logic [15:0] res_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  logic [1:0] phase = 2'd0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] raw;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];

  ramp_adc_scheduler dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ch_enable(ch_enable),
    .duty_data(duty_data), .mux_sel(mux_sel), .sample_active(sample_active),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_channel(res_channel), .res_raw(res_raw), .res_data(res_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: all zero, 1: all one, 2: period-4 pattern so every other strobed sample is 1
  initial begin
    forever begin
      @(negedge clk);
      phase = phase + 2'd1;
      duty_data = (mode == 2) ? phase[1] : (mode == 1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] ch, input int m);
    exp_t e;
    e.ch   = ch;
    e.raw  = (m == 1) ? 16'hFFFF : (m == 2) ? 16'h8000 : 16'h0000;
    e.data = 16'((64'(e.raw) * 64'(SF)) >> SH);
    sbq.push_back(e);
    mode = m;
  endtask

  task automatic get_result(input string tag);
    exp_t e;
    int n = 0;
    bit mux_ok = 1'b1;
    bit have = (sbq.size() > 0);
    total++;
    assert (have) else begin
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (have) begin
      e = sbq.pop_front();
      do begin
        @(negedge clk);
        n++;
        if (busy && !res_valid && mux_sel !== e.ch) mux_ok = 1'b0;
      end while (res_valid !== 1'b1 && n < 2000);
      check({tag, "_timeout"}, 64'(n < 2000), 64'd1);
      check({tag, "_ch"}, 64'(res_channel), 64'(e.ch));
      check({tag, "_raw"}, 64'(res_raw), 64'(e.raw));
      check({tag, "_data"}, 64'(res_data), 64'(e.data));
      check({tag, "_mux"}, 64'(mux_ok), 64'd1);
    end
  endtask

  task automatic wait_acquire(input string tag);
    int n = 0;
    while (sample_active !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_acq_to"}, 64'(sample_active), 64'd1);
  endtask

  initial begin
    int n;
    int c0;
    bit ok;
    logic [1:0]  h_ch;
    logic [15:0] h_raw;
    logic [15:0] h_data;
    logic [1:0] rr_seq [5] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    repeat (3) @(negedge clk);
    check("rst_outs", 64'({mux_sel, sample_active, busy, res_valid, res_channel, res_raw, res_data}), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(res_valid), 64'd0);

    // Full scale with latency measured from the first SETTLE cycle.
    ch_enable = 4'b0001;
    res_ready = 1'b1;
    push_exp(2'd0, 1);
    run = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_to", 64'(busy), 64'd1);
    c0 = cyc;
    get_result("full");
    check("latency", 64'(cyc - c0), 64'd530);

    push_exp(2'd0, 1);
    get_result("repeat");
    push_exp(2'd0, 0);
    get_result("zero");
    push_exp(2'd0, 2);
    get_result("half");

    ch_enable = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      push_exp(rr_seq[k], k % 3);
      get_result($sformatf("rr%0d", k));
    end

    // Backpressure on the next channel (0).
    @(negedge clk);
    res_ready = 1'b0;
    push_exp(2'd0, 1);
    get_result("bp");
    h_ch = res_channel;
    h_raw = res_raw;
    h_data = res_data;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_channel !== h_ch || res_raw !== h_raw ||
          res_data !== h_data || sample_active !== 1'b0 || mux_sel !== 2'd0 || busy !== 1'b1)
        ok = 1'b0;
    end
    check("bp_hold", 64'(ok), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(res_valid), 64'd0);
    check("bp_release_busy", 64'(busy), 64'd1);
    push_exp(2'd1, 2);
    get_result("after_bp");

    // Drop run mid-acquire: result still delivered, then IDLE.
    push_exp(2'd3, 1);
    wait_acquire("stop");
    run = 1'b0;
    get_result("stop");
    @(negedge clk);
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_valid", 64'(res_valid), 64'd0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 1'b0;
    end
    check("stop_idle", 64'(ok), 64'd1);

    // Empty mask with run=1.
    ch_enable = 4'b0000;
    run = 1'b1;
    ok = 1'b1;
    repeat (600) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0) ok = 1'b0;
    end
    check("empty_mask", 64'(ok), 64'd1);

    // Asynchronous reset mid-acquire.
    ch_enable = 4'b1001;
    mode = 1;
    wait_acquire("rst_mid");
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_outs", 64'({mux_sel, sample_active, busy, res_valid, res_channel, res_raw, res_data}), 64'd0);
    @(negedge clk);
    run = 1'b0;
    reset_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0) ok = 1'b0;
    end
    check("rst_release_idle", 64'(ok), 64'd1);

    // After reset the search starts at channel 0.
    push_exp(2'd0, 2);
    run = 1'b1;
    get_result("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
